uart_txq: RTL and testbench

UART_TXQ -- requirements
Module: uart_txq

---
 rtl/uart_txq_pkg.sv | 21 ++
 rtl/uart_txq_fifo.sv | 46 ++++
 rtl/uart_txq.sv | 122 ++++++++++++
 tb/tb_uart_txq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_txq_pkg.sv
// Shared types and constants for the uart_txq transmit queue.
package uart_txq_pkg;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_BAUD_DIV = 16;
    localparam int FRAME_BITS   = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    typedef struct packed {
        logic       cen;
        logic       wr;
        logic [7:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/uart_txq_fifo.sv
// Byte FIFO for uart_txq; occupancy counter sized 0..DEPTH, pointers wrap modulo DEPTH.
module uart_txq_fifo
    import uart_txq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          push_ok, pop_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_txq.sv
// Write-only UART transmitter with a byte FIFO in front of an 8N1 serialiser.
// Optional macro UART_TXQ_SIM_PRINT_EN echoes each popped byte to the console.
module uart_txq
    import uart_txq_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cen,
    input  logic                     wr,
    input  logic [7:0]               wdata,
    output logic                     error,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    bus_req_t  req;
    tx_state_e state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    head;
    logic          full, empty, push, pop, bit_end;

    assign req     = '{cen: cen, wr: wr, wdata: wdata};
    assign error   = req.cen & (~req.wr | full);
    assign push    = req.cen & req.wr & ~full;
    assign bit_end = (cnt == CW'(BAUD_DIV - 1));
    // Pop decision looks only at pre-edge emptiness, so a byte written this cycle waits one edge.
    assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign busy    = (state != IDLE) | ~empty;

    uart_txq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata (req.wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    txd <= 1'b1;
                    if (pop) begin
                        state <= START;
                        shreg <= head;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        txd     <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (pop) begin
                            state <= START;
                            shreg <= head;
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

`ifdef UART_TXQ_SIM_PRINT_EN
    always_ff @(posedge clk) begin
        if (rstn && pop)
            $write("%c", head);
    end
`else
`endif

endmodule

// File: tb/tb_uart_txq.sv
// Randomised bench for uart_txq against a queue-and-frame-timer reference model.
module tb_uart_txq;
    import uart_txq_pkg::*;

    localparam int DEPTH = 4;
    localparam int BD    = 4;
    localparam int FRAME = FRAME_BITS * BD;

    logic       clk = 1'b0;
    logic       rstn = 1'b0, cen = 1'b0, wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       error, txd, busy;
    logic [2:0] level;

    always #5 clk = ~clk;

    uart_txq #(.DEPTH(DEPTH), .BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .cen   (cen),
        .wr    (wr),
        .wdata (wdata),
        .error (error),
        .txd   (txd),
        .busy  (busy),
        .level (level)
    );

    int total = 0;
    int bad   = 0;

    // Model: pending bytes, plus the byte on the wire and cycles elapsed in its frame.
    logic [7:0] q[$];
    bit         active = 0;
    int         t = 0;
    logic [7:0] cur = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic line_bit();
        int k;
        if (!active) return 1'b1;
        k = t / BD;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    task automatic cyc(input logic r, input logic c, input logic w, input logic [7:0] d);
        bit full, perr, ppush;
        rstn = r; cen = c; wr = w; wdata = d;
        #1;
        full  = (q.size() == DEPTH);
        perr  = c && (!w || full);
        ppush = c && w && !full;
        chk("error", {31'b0, error}, {31'b0, perr});
        @(posedge clk);
        if (!r) begin
            q.delete();
            active = 0;
            t = 0;
        end else begin
            if (active) begin
                t++;
                if (t == FRAME) begin
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        t = 0;
                    end else begin
                        active = 0;
                    end
                end
            end else if (q.size() > 0) begin
                cur = q.pop_front();
                active = 1;
                t = 0;
            end
            if (ppush) q.push_back(d);
        end
        @(negedge clk);
        chk("txd",   {31'b0, txd},  {31'b0, line_bit()});
        chk("level", {29'b0, level}, q.size());
        chk("busy",  {31'b0, busy}, {31'b0, (active || q.size() > 0)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wrb(input logic [7:0] d);
        cyc(1'b1, 1'b1, 1'b1, d);
    endtask

    initial begin
        // reset state
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // single frame, alternating pattern
        wrb(8'h55);
        idle(45);

        // back-to-back frames
        wrb(8'h41);
        wrb(8'h42);
        idle(85);

        // overfill during first frame
        wrb(8'h11);
        idle(10);
        for (int i = 0; i < 6; i++) wrb(8'h20 + 8'(i));
        idle(5 * FRAME + 10);

        // read attempts are errors, mid-frame and idle
        wrb(8'hC3);
        idle(7);
        cyc(1'b1, 1'b1, 1'b0, 8'hFF);
        idle(3);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        idle(FRAME);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        idle(2);

        // reset mid-DATA with level 3, then recover
        for (int i = 0; i < 4; i++) wrb(8'h70 + 8'(i));
        idle(8);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        idle(2);
        wrb(8'hA5);
        idle(45);

        // random traffic: dense then sparse, occasional reset
        for (int i = 0; i < 1600; i++) begin
            logic r, c, w;
            r = ($urandom_range(199) != 0);
            c = (i < 800) ? ($urandom_range(4) == 0) : ($urandom_range(49) == 0);
            w = ($urandom_range(7) != 0);
            cyc(r, c, w, 8'($urandom));
        end
        idle(5 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
